// File: rtl/mux_cfg_pkg.sv
// Shared types and helpers for the 3:1 routing-mux configuration loader.
// A select pair is {sel2, sel1}; 2'b11 is not a valid mux encoding.
package mux_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    localparam logic [1:0] SEL_A       = 2'b00;
    localparam logic [1:0] SEL_B       = 2'b01;
    localparam logic [1:0] SEL_C       = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    // Returns {legal_pair, err}; an illegal pair falls back to input a.
    function automatic logic [2:0] sanitize_sel(input logic [1:0] pair);
        if (pair == SEL_ILLEGAL) begin
            return {SEL_A, 1'b1};
        end
        return {pair, 1'b0};
    endfunction

endpackage

// File: rtl/mux_cfg_shreg.sv
// W-bit serial configuration chain: new bits enter at the top, the oldest
// bit leaves from bit 0 through a register so loaders can be daisy-chained.
module mux_cfg_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         scan_in,
    output logic [W-1:0] q,
    output logic         scan_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            scan_out <= 1'b0;
        end else if (shift_en) begin
            q        <= {scan_in, q[W-1:1]};
            scan_out <= q[0];
        end
    end

endmodule

// File: rtl/mux_cfg_loader.sv
// Serial loader for the routing-mux selects: shifts in one frame, then
// validates and commits every {sel2, sel1} pair on a single edge.
//
//   state  | meaning
//   IDLE   | waiting for cfg_start; sel*_o hold the last committed frame
//   SHIFT  | accepting scan bits while scan_valid; cfg_start restarts the frame
//   COMMIT | one cycle: sanitize all pairs and update sel*_o together
module mux_cfg_loader #(
    parameter int NUM_MUX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic               scan_in,
    input  logic               scan_valid,
    output logic               scan_ready,
    output logic               scan_out,
    output logic [NUM_MUX-1:0] sel1_o,
    output logic [NUM_MUX-1:0] sel2_o,
    output logic               cfg_done,
    output logic               cfg_err,
    output logic               cfg_loaded
);
    import mux_cfg_pkg::*;

    localparam int W  = 2 * NUM_MUX;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    cfg_state_t         state;
    logic [CW-1:0]      cnt;
    logic [W-1:0]       shreg;
    logic               shift_en;
    logic [NUM_MUX-1:0] sel1_n;
    logic [NUM_MUX-1:0] sel2_n;
    logic               err_n;

    // A restart takes priority over a bit offered in the same cycle.
    assign shift_en = (state == SHIFT) && scan_valid && !cfg_start;

    mux_cfg_shreg #(
        .W(W)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .shift_en(shift_en),
        .scan_in (scan_in),
        .q       (shreg),
        .scan_out(scan_out)
    );

    always_comb begin
        logic [2:0] san;
        san    = '0;
        sel1_n = '0;
        sel2_n = '0;
        err_n  = 1'b0;
        for (int i = 0; i < NUM_MUX; i++) begin
            san       = sanitize_sel({shreg[2*i+1], shreg[2*i]});
            sel2_n[i] = san[2];
            sel1_n[i] = san[1];
            err_n     = err_n | san[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sel1_o     <= '0;
            sel2_o     <= '0;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_loaded <= 1'b0;
            scan_ready <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state      <= SHIFT;
                        cnt        <= '0;
                        cfg_err    <= 1'b0;
                        scan_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cfg_start) begin
                        cnt     <= '0;
                        cfg_err <= 1'b0;
                    end else if (scan_valid) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_BIT) begin
                            state      <= COMMIT;
                            scan_ready <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    sel1_o     <= sel1_n;
                    sel2_o     <= sel2_n;
                    cfg_err    <= err_n;
                    cfg_done   <= 1'b1;
                    cfg_loaded <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    scan_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
